clint_trap_seq: RTL and testbench
=================================

Name: clint_trap_seq

Overview:
- Core-side trap sequencer; the initiating end of the CSR register-file write port (we/addr/data).
- On a synchronous exception (ecall/ebreak), an enabled interrupt, or mret, it:
  - stalls the pipeline;
  - issues an ordered series of single-cycle CSR writes (mepc, mstatus, mcause);
  - pulses a redirect to the trap vector or return address.
- Sits between decode/execute and the CSR file.

Parameters:
- INT_NUM, 8, number of interrupt request lines; bit 0 is the machine timer.
- RESET_PC, 32'h0, value of int_addr_o during and after reset.

Ports:
- clk  input  1  core clock
- rst  input  1  asynchronous reset, active-low
- int_flag_i  input  INT_NUM  level interrupt requests; bit 0 = timer
- ecall_i  input  1  decode: current instruction is ecall
- ebreak_i  input  1  decode: current instruction is ebreak
- mret_i  input  1  decode: current instruction is mret
- inst_addr_i  input  32  PC of the current decode instruction
- busy_i  input  1  multi-cycle op in flight (divider); blocks interrupt acceptance
- csr_mtvec_i  input  32  current mtvec
- csr_mepc_i  input  32  current mepc
- csr_mstatus_i  input  32  current mstatus
- we_o  output  1  CSR write enable
- waddr_o  output  12  CSR write address
- data_o  output  32  CSR write data
- hold_o  output  1  pipeline hold request
- int_assert_o  output  1  one-cycle redirect pulse
- int_addr_o  output  32  redirect target, valid when int_assert_o=1

Behaviour:
- Reset (rst=0, async): state=IDLE, we_o=0, waddr_o=0, data_o=0, hold_o=0, int_assert_o=0, int_addr_o=RESET_PC, latched cause/epc=0.
- Priority in IDLE, evaluated each cycle:
  1. ecall/ebreak
  2. mret
  3. interrupt — accepted only when all hold:
     - mstatus.MIE (bit 3)=1
     - busy_i=0
     - no ecall/ebreak/mret this cycle
     - some int_flag_i bit set
  - Lowest-index active interrupt line wins.
- Cause codes:
  - ecall = 32'd11
  - ebreak = 32'd3
  - interrupt bit 0 = 32'h8000_0007
  - interrupt bit k>0 = 32'h8000_0000 | (16+k)
- EPC value:
  - exceptions: inst_addr_i
  - interrupts: inst_addr_i (the interrupted instruction is re-executed)
- hold_o: combinationally 1 in the detection cycle (IDLE with an accepted event), and registered 1 in every non-IDLE state.
- Trap FSM, one CSR write per cycle, we_o=1 in each write state:
  - S_MEPC: waddr=0x341, data=epc.
  - S_MSTATUS: waddr=0x300, data = mstatus with MPIE(bit 7) ← MIE, MIE ← 0.
  - S_MCAUSE: waddr=0x342, data=cause.
  - S_ASSERT: we_o=0, int_assert_o=1, int_addr_o=mtvec base (mtvec & ~3), then back to IDLE.
  - Latency: detection cycle D, writes D+1..D+3, redirect at D+4.
- mret FSM:
  - S_MRET: waddr=0x300, data = mstatus with MIE ← MPIE, MPIE ← 1.
  - S_ASSERT: int_addr_o = csr_mepc_i as sampled at D+1.
  - Redirect at D+2.
- Events arriving while not IDLE are ignored; level interrupts remain pending and are re-evaluated in IDLE.
- Back-to-back: the IDLE cycle following S_ASSERT may accept a new event.
- int_addr_o holds its last value when int_assert_o=0.
- Reset mid-sequence aborts immediately to IDLE; partial CSR writes are not undone.

Optional Feature:
- CLINT_VECTORED_EN defined: when mtvec[1:0]==2'b01 and the trap is an interrupt, int_addr_o = base + 4*(cause & 32'h7FFF_FFFF). Exceptions still go to base.
- Undefined: mode bits are ignored; all traps go to base.

Decomposition:
- Shared package/defines: CSR addresses (MSTATUS 0x300, MTVEC 0x305, MEPC 0x341, MCAUSE 0x342), cause constants, mstatus bit indices (MIE=3, MPIE=7), FSM state encoding.
- One natural sub-module: clint_int_prio, a combinational lowest-index priority encoder producing the valid flag and cause code from int_flag_i.

Test Plan:
- ecall at PC 0x100, mtvec=0x200, mstatus=0x8 → writes (0x341,0x100), (0x300,0x80), (0x342,11) on D+1..D+3; int_assert_o with int_addr_o=0x200 at D+4; hold_o=1 on D..D+4.
- int_flag_i=8'h01, MIE=1, PC 0x40 → mcause write 0x8000_0007, redirect to mtvec base.
- int_flag_i=8'h06 with busy_i=1 for 3 cycles → no action while busy; then mcause=0x8000_0011 (bit 1 wins).
- mret with mepc=0x144, mstatus=0x80 → write (0x300,0x88) at D+1; redirect to 0x144 at D+2.
- ecall and int_flag_i=1 in the same cycle → ecall serviced first (cause 11); interrupt taken only if MIE=1 after return.
- rst low during S_MSTATUS → all outputs at reset values immediately; with CLINT_VECTORED_EN, mtvec=0x201 and timer interrupt → int_addr_o=0x21C.

Source files
------------

// File: rtl/clint_trap_seq_pkg.sv
// Shared definitions for the trap sequencer: CSR addresses, cause codes,
// mstatus bit positions, FSM state encoding and mstatus rewrite helpers.
package clint_trap_seq_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [31:0] CAUSE_ECALL     = 32'd11;
  localparam logic [31:0] CAUSE_EBREAK    = 32'd3;
  localparam logic [31:0] CAUSE_INT_TIMER = 32'h8000_0007;
  // External line k (k>0) maps to interrupt code 16+k.
  localparam logic [31:0] CAUSE_INT_BASE  = 32'h8000_0010;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MEPC,
    S_MSTATUS,
    S_MCAUSE,
    S_MRET,
    S_ASSERT
  } state_e;

  // Trap entry: stash MIE into MPIE and disable interrupts.
  function automatic logic [31:0] mstatus_on_trap(input logic [31:0] ms);
    logic [31:0] r;
    r               = ms;
    r[MSTATUS_MPIE] = ms[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    return r;
  endfunction

  // Trap return: restore MIE from MPIE and set MPIE.
  function automatic logic [31:0] mstatus_on_mret(input logic [31:0] ms);
    logic [31:0] r;
    r               = ms;
    r[MSTATUS_MIE]  = ms[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/clint_trap_seq_if.sv
// CSR register-file write port driven by the trap sequencer.
interface clint_trap_seq_if;
  logic        we_o;
  logic [11:0] waddr_o;
  logic [31:0] data_o;

  modport master (output we_o, waddr_o, data_o);
  modport slave  (input  we_o, waddr_o, data_o);
endinterface

// File: rtl/clint_int_prio.sv
// Lowest-index-wins interrupt priority encoder; line 0 is the machine timer.
module clint_int_prio
  import clint_trap_seq_pkg::*;
#(
  parameter int INT_NUM = 8
) (
  input  logic [INT_NUM-1:0] i_flag,
  output logic               o_vld,
  output logic [31:0]        o_cause
);

  // Scan from the top down so the lowest active line is written last and wins.
  always_comb begin
    o_vld   = 1'b0;
    o_cause = '0;
    for (int k = INT_NUM - 1; k >= 0; k--) begin
      if (i_flag[k]) begin
        o_vld   = 1'b1;
        o_cause = (k == 0) ? CAUSE_INT_TIMER : (CAUSE_INT_BASE + 32'(k));
      end
    end
  end

endmodule

// File: rtl/clint_trap_seq.sv
// Core-side trap sequencer: on ecall/ebreak, an enabled interrupt or mret it
// holds the pipeline, writes mepc/mstatus/mcause one per cycle over the CSR
// port and pulses a redirect. Optional macro CLINT_VECTORED_EN enables
// vectored interrupt targets when mtvec mode is 2'b01.
module clint_trap_seq
  import clint_trap_seq_pkg::*;
#(
  parameter int          INT_NUM  = 8,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INT_NUM-1:0] int_flag_i,
  input  logic               ecall_i,
  input  logic               ebreak_i,
  input  logic               mret_i,
  input  logic [31:0]        inst_addr_i,
  input  logic               busy_i,
  input  logic [31:0]        csr_mtvec_i,
  input  logic [31:0]        csr_mepc_i,
  input  logic [31:0]        csr_mstatus_i,
  clint_trap_seq_if.master   csr_wr,
  output logic               hold_o,
  output logic               int_assert_o,
  output logic [31:0]        int_addr_o
);

  state_e      r_state;
  state_e      w_next;
  logic [31:0] r_cause;
  logic [31:0] r_epc;
  logic [31:0] r_int_addr;

  logic        w_int_vld;
  logic [31:0] w_int_cause;
  logic        w_exc;
  logic        w_int_ok;
  logic [31:0] w_trap_base;
  logic [31:0] w_trap_target;

  clint_int_prio #(.INT_NUM(INT_NUM)) u_prio (
    .i_flag  (int_flag_i),
    .o_vld   (w_int_vld),
    .o_cause (w_int_cause)
  );

  assign w_exc       = ecall_i | ebreak_i;
  assign w_int_ok    = csr_mstatus_i[MSTATUS_MIE] & ~busy_i & ~w_exc & ~mret_i & w_int_vld;
  assign w_trap_base = csr_mtvec_i & ~32'h3;

`ifdef CLINT_VECTORED_EN
  logic r_is_int;

  // Remember whether the sequence in flight is an interrupt (vectoring applies only to those).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                  r_is_int <= 1'b0;
    else if (r_state == S_IDLE && (w_exc || w_int_ok)) r_is_int <= ~w_exc;
  end

  assign w_trap_target = (r_is_int && csr_mtvec_i[1:0] == 2'b01)
                         ? w_trap_base + ((r_cause & 32'h7FFF_FFFF) << 2)
                         : w_trap_base;
`else
  assign w_trap_target = w_trap_base;
`endif

  // State register; reset aborts any sequence in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Latch cause/EPC at detection and the redirect target one cycle before the pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cause    <= '0;
      r_epc      <= '0;
      r_int_addr <= RESET_PC;
    end else begin
      if (r_state == S_IDLE && (w_exc || w_int_ok)) begin
        r_cause <= w_exc ? (ecall_i ? CAUSE_ECALL : CAUSE_EBREAK) : w_int_cause;
        r_epc   <= inst_addr_i;
      end
      if (r_state == S_MCAUSE)    r_int_addr <= w_trap_target;
      else if (r_state == S_MRET) r_int_addr <= csr_mepc_i;
    end
  end

  assign int_addr_o = r_int_addr;

  // Next-state and per-state CSR write / hold / redirect decode.
  always_comb begin
    w_next         = r_state;
    csr_wr.we_o    = 1'b0;
    csr_wr.waddr_o = '0;
    csr_wr.data_o  = '0;
    hold_o         = 1'b0;
    int_assert_o   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_exc || w_int_ok) begin
          hold_o = 1'b1;
          w_next = S_MEPC;
        end else if (mret_i) begin
          hold_o = 1'b1;
          w_next = S_MRET;
        end
      end
      S_MEPC: begin
        hold_o         = 1'b1;
        csr_wr.we_o    = 1'b1;
        csr_wr.waddr_o = CSR_MEPC;
        csr_wr.data_o  = r_epc;
        w_next         = S_MSTATUS;
      end
      S_MSTATUS: begin
        hold_o         = 1'b1;
        csr_wr.we_o    = 1'b1;
        csr_wr.waddr_o = CSR_MSTATUS;
        csr_wr.data_o  = mstatus_on_trap(csr_mstatus_i);
        w_next         = S_MCAUSE;
      end
      S_MCAUSE: begin
        hold_o         = 1'b1;
        csr_wr.we_o    = 1'b1;
        csr_wr.waddr_o = CSR_MCAUSE;
        csr_wr.data_o  = r_cause;
        w_next         = S_ASSERT;
      end
      S_MRET: begin
        hold_o         = 1'b1;
        csr_wr.we_o    = 1'b1;
        csr_wr.waddr_o = CSR_MSTATUS;
        csr_wr.data_o  = mstatus_on_mret(csr_mstatus_i);
        w_next         = S_ASSERT;
      end
      S_ASSERT: begin
        hold_o       = 1'b1;
        int_assert_o = 1'b1;
        w_next       = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_clint_trap_seq.sv
// Directed testbench for clint_trap_seq: table of single-event sequences
// plus hand-written busy, collision, reset-abort and re-evaluation cases.
module tb_clint_trap_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  int_flag_i = '0;
  logic        ecall_i = 1'b0, ebreak_i = 1'b0, mret_i = 1'b0, busy_i = 1'b0;
  logic [31:0] inst_addr_i = '0, csr_mtvec_i = '0, csr_mepc_i = '0, csr_mstatus_i = '0;
  logic        hold_o, int_assert_o;
  logic [31:0] int_addr_o;

  int checks   = 0;
  int failures = 0;

  clint_trap_seq_if u_if ();

  clint_trap_seq #(.INT_NUM(8), .RESET_PC(32'h0)) dut (
    .clk           (clk),
    .rst           (rst),
    .int_flag_i    (int_flag_i),
    .ecall_i       (ecall_i),
    .ebreak_i      (ebreak_i),
    .mret_i        (mret_i),
    .inst_addr_i   (inst_addr_i),
    .busy_i        (busy_i),
    .csr_mtvec_i   (csr_mtvec_i),
    .csr_mepc_i    (csr_mepc_i),
    .csr_mstatus_i (csr_mstatus_i),
    .csr_wr        (u_if),
    .hold_o        (hold_o),
    .int_assert_o  (int_assert_o),
    .int_addr_o    (int_addr_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        ecall, ebreak, mret;
    logic [7:0]  flags;
    logic [31:0] pc, mtvec, mepc, mstatus;
    logic        is_mret;
    logic [31:0] epc, ms_exp, cause, target;
  } vec_t;

  function automatic vec_t mk(input string n, input logic ec, input logic eb, input logic mr,
                              input logic [7:0] fl, input logic [31:0] pc, input logic [31:0] tv,
                              input logic [31:0] mepc, input logic [31:0] ms, input logic ism,
                              input logic [31:0] epc, input logic [31:0] mse,
                              input logic [31:0] cs, input logic [31:0] tg);
    vec_t v;
    v.name = n; v.ecall = ec; v.ebreak = eb; v.mret = mr; v.flags = fl;
    v.pc = pc; v.mtvec = tv; v.mepc = mepc; v.mstatus = ms; v.is_mret = ism;
    v.epc = epc; v.ms_exp = mse; v.cause = cs; v.target = tg;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_events();
    ecall_i = 1'b0; ebreak_i = 1'b0; mret_i = 1'b0; int_flag_i = '0;
  endtask

  // Drive one event from IDLE and follow it through to the IDLE cycle after the redirect.
  task automatic run_vec(input vec_t v);
    ecall_i = v.ecall; ebreak_i = v.ebreak; mret_i = v.mret; int_flag_i = v.flags;
    inst_addr_i = v.pc; csr_mtvec_i = v.mtvec; csr_mepc_i = v.mepc;
    csr_mstatus_i = v.mstatus; busy_i = 1'b0;
    @(negedge clk);
    chk({v.name, ".D.hold"}, 32'(hold_o), 32'd1);
    chk({v.name, ".D.we"}, 32'(u_if.we_o), 32'd0);
    tick();
    clear_events();
    if (!v.is_mret) begin
      @(negedge clk);
      chk({v.name, ".mepc.we"}, 32'(u_if.we_o), 32'd1);
      chk({v.name, ".mepc.addr"}, 32'(u_if.waddr_o), 32'h341);
      chk({v.name, ".mepc.data"}, u_if.data_o, v.epc);
      chk({v.name, ".mepc.hold"}, 32'(hold_o), 32'd1);
      tick();
      @(negedge clk);
      chk({v.name, ".mstatus.addr"}, 32'(u_if.waddr_o), 32'h300);
      chk({v.name, ".mstatus.data"}, u_if.data_o, v.ms_exp);
      tick();
      @(negedge clk);
      chk({v.name, ".mcause.addr"}, 32'(u_if.waddr_o), 32'h342);
      chk({v.name, ".mcause.data"}, u_if.data_o, v.cause);
    end else begin
      @(negedge clk);
      chk({v.name, ".mret.we"}, 32'(u_if.we_o), 32'd1);
      chk({v.name, ".mret.addr"}, 32'(u_if.waddr_o), 32'h300);
      chk({v.name, ".mret.data"}, u_if.data_o, v.ms_exp);
    end
    tick();
    @(negedge clk);
    chk({v.name, ".assert"}, 32'(int_assert_o), 32'd1);
    chk({v.name, ".target"}, int_addr_o, v.target);
    chk({v.name, ".assert.we"}, 32'(u_if.we_o), 32'd0);
    chk({v.name, ".assert.hold"}, 32'(hold_o), 32'd1);
    tick();
    @(negedge clk);
    chk({v.name, ".after.assert"}, 32'(int_assert_o), 32'd0);
    chk({v.name, ".after.hold"}, 32'(hold_o), 32'd0);
    chk({v.name, ".after.addr_held"}, int_addr_o, v.target);
    tick();
  endtask

  vec_t vecs[8];

  initial begin
    // Table of single-event sequences with hand-computed results.
    vecs[0] = mk("ecall",   1,0,0, 8'h00, 32'h100, 32'h200, 32'h0,    32'h08, 0, 32'h100, 32'h80, 32'd11,         32'h200);
    vecs[1] = mk("ebreak",  0,1,0, 8'h00, 32'h104, 32'h203, 32'h0,    32'h00, 0, 32'h104, 32'h00, 32'd3,          32'h200);
    vecs[2] = mk("timer",   0,0,0, 8'h01, 32'h040, 32'h300, 32'h0,    32'h08, 0, 32'h040, 32'h80, 32'h8000_0007,  32'h300);
    vecs[3] = mk("irq7",    0,0,0, 8'h80, 32'h044, 32'h400, 32'h0,    32'h88, 0, 32'h044, 32'h80, 32'h8000_0017,  32'h400);
    vecs[4] = mk("mret",    0,0,1, 8'h00, 32'h050, 32'h200, 32'h144,  32'h80, 1, 32'h0,   32'h88, 32'h0,          32'h144);
    vecs[5] = mk("mret2",   0,0,1, 8'h00, 32'h054, 32'h200, 32'h2000, 32'h08, 1, 32'h0,   32'h80, 32'h0,          32'h2000);
`ifdef CLINT_VECTORED_EN
    vecs[6] = mk("vec_tmr", 0,0,0, 8'h01, 32'h058, 32'h201, 32'h0,    32'h08, 0, 32'h058, 32'h80, 32'h8000_0007,  32'h21C);
    vecs[7] = mk("vec_irq2",0,0,0, 8'h0C, 32'h05C, 32'h201, 32'h0,    32'h08, 0, 32'h05C, 32'h80, 32'h8000_0012,  32'h248);
`else
    vecs[6] = mk("vec_tmr", 0,0,0, 8'h01, 32'h058, 32'h201, 32'h0,    32'h08, 0, 32'h058, 32'h80, 32'h8000_0007,  32'h200);
    vecs[7] = mk("vec_irq2",0,0,0, 8'h0C, 32'h05C, 32'h201, 32'h0,    32'h08, 0, 32'h05C, 32'h80, 32'h8000_0012,  32'h200);
`endif

    // Reset state while rst is held low.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.we", 32'(u_if.we_o), 32'd0);
    chk("rst.waddr", 32'(u_if.waddr_o), 32'd0);
    chk("rst.data", u_if.data_o, 32'd0);
    chk("rst.hold", 32'(hold_o), 32'd0);
    chk("rst.assert", 32'(int_assert_o), 32'd0);
    chk("rst.addr", int_addr_o, 32'h0);
    tick();
    rst = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Busy blocks interrupt acceptance; line 1 wins once busy drops.
    int_flag_i = 8'h06; csr_mstatus_i = 32'h08; inst_addr_i = 32'h060;
    csr_mtvec_i = 32'h500; busy_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("busy%0d.hold", i), 32'(hold_o), 32'd0);
      chk($sformatf("busy%0d.we", i), 32'(u_if.we_o), 32'd0);
      tick();
    end
    run_vec(mk("busy_rel", 0,0,0, 8'h06, 32'h060, 32'h500, 32'h0, 32'h08, 0,
               32'h060, 32'h80, 32'h8000_0011, 32'h500));

    // ecall and timer together: ecall first, pending interrupt waits for MIE.
    ecall_i = 1'b1; int_flag_i = 8'h01; csr_mstatus_i = 32'h08;
    inst_addr_i = 32'h080; csr_mtvec_i = 32'h600;
    @(negedge clk);
    chk("coll.D.hold", 32'(hold_o), 32'd1);
    tick();
    ecall_i = 1'b0;
    @(negedge clk);
    chk("coll.mepc.data", u_if.data_o, 32'h080);
    tick(); tick();
    @(negedge clk);
    chk("coll.mcause.data", u_if.data_o, 32'd11);
    tick();
    @(negedge clk);
    chk("coll.assert", 32'(int_assert_o), 32'd1);
    chk("coll.target", int_addr_o, 32'h600);
    csr_mstatus_i = 32'h80;
    tick();
    @(negedge clk);
    chk("coll.mie0.hold", 32'(hold_o), 32'd0);
    csr_mstatus_i = 32'h08;
    #1;
    chk("coll.mie1.hold", 32'(hold_o), 32'd1);
    tick();
    @(negedge clk);
    chk("coll.int.mepc.addr", 32'(u_if.waddr_o), 32'h341);
    tick(); tick();
    @(negedge clk);
    chk("coll.int.mcause.data", u_if.data_o, 32'h8000_0007);
    int_flag_i = '0;
    tick();
    @(negedge clk);
    chk("coll.int.assert", 32'(int_assert_o), 32'd1);
    tick();

    // Reset in the middle of S_MSTATUS aborts immediately.
    ecall_i = 1'b1; inst_addr_i = 32'h090; csr_mtvec_i = 32'h700; csr_mstatus_i = 32'h08;
    tick();
    ecall_i = 1'b0;
    tick();
    @(negedge clk);
    chk("abort.pre.addr", 32'(u_if.waddr_o), 32'h300);
    #1 rst = 1'b0;
    #1;
    chk("abort.we", 32'(u_if.we_o), 32'd0);
    chk("abort.waddr", 32'(u_if.waddr_o), 32'd0);
    chk("abort.data", u_if.data_o, 32'd0);
    chk("abort.hold", 32'(hold_o), 32'd0);
    chk("abort.assert", 32'(int_assert_o), 32'd0);
    chk("abort.addr", int_addr_o, 32'h0);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("abort.idle.hold", 32'(hold_o), 32'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
